// File: rtl/adam_periph_uart_rx_if.sv
// Stream and pause handshake bundle for the UART receive engine.
// master: the receiver side (drives data/valid/ack); slave: consumer and pause controller.
interface adam_periph_uart_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  req;
    logic                  ack;

    modport master (output data, output valid, output ack, input ready, input req);
    modport slave  (input data, input valid, input ack, output ready, output req);
endinterface

// File: rtl/adam_periph_uart_rx.sv
// UART receive engine: samples rx mid-bit and delivers each word on the stream port.
// Define ADAM_PERIPH_UART_RX_MAJORITY_EN for 3-sample majority voting (one cycle later per sample).
//
//   state  | meaning
//   IDLE   | line idle, waiting for start edge; pause ack tracks req
//   START  | half a bit period in, confirm start bit is still low
//   DATA   | sampling data bits, LSB first
//   PARITY | sampling and checking the parity bit
//   STOP   | sampling one or two stop bits
module adam_periph_uart_rx #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    adam_periph_uart_rx_if.master bus,
    input  logic                  parity_select,
    input  logic                  parity_control,
    input  logic [3:0]            data_length,
    input  logic                  stop_bits,
    input  logic [DATA_WIDTH-1:0] baud_rate,
    input  logic                  rx,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] word, word_nxt;
    logic [3:0]            bit_idx, bit_idx_nxt;
    logic                  stop_idx, stop_idx_nxt;
    logic                  par_acc, par_acc_nxt;
    logic                  par_bad, par_bad_nxt;
    logic                  frm_bad, frm_bad_nxt;
    logic                  frame_done;

    logic rx_meta, rx_s, rx_d1;
    logic sample, fall, tick, start_go;
    logic [DATA_WIDTH-1:0] start_load;

`ifdef ADAM_PERIPH_UART_RX_MAJORITY_EN
    logic rx_d2;

    always_ff @(posedge clk) begin
        if (rst) rx_d2 <= 1'b1;
        else     rx_d2 <= rx_d1;
    end

    // Vote over mid-1, mid, mid+1; the extra cycle of delay is absorbed in the start load.
    assign sample     = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
    assign start_load = baud_rate >> 1;
`else
    assign sample     = rx_s;
    assign start_load = (baud_rate >> 1) - DATA_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d1   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d1   <= rx_s;
        end
    end

    assign fall     = rx_d1 & ~rx_s;
    assign tick     = (cnt == '0);
    assign start_go = (state == IDLE) && fall && !bus.req && !bus.ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            word     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            frm_bad  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            word     <= word_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_idx <= stop_idx_nxt;
            par_acc  <= par_acc_nxt;
            par_bad  <= par_bad_nxt;
            frm_bad  <= frm_bad_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = tick ? baud_rate : cnt - DATA_WIDTH'(1);
        word_nxt     = word;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        par_acc_nxt  = par_acc;
        par_bad_nxt  = par_bad;
        frm_bad_nxt  = frm_bad;
        frame_done   = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (start_go) begin
                    state_nxt    = START;
                    cnt_nxt      = start_load;
                    word_nxt     = '0;
                    bit_idx_nxt  = '0;
                    stop_idx_nxt = 1'b0;
                    par_acc_nxt  = 1'b0;
                    par_bad_nxt  = 1'b0;
                    frm_bad_nxt  = 1'b0;
                end
            end
            START: begin
                if (tick) state_nxt = sample ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    word_nxt    = word | (DATA_WIDTH'(sample) << bit_idx);
                    par_acc_nxt = par_acc ^ sample;
                    bit_idx_nxt = bit_idx + 4'd1;
                    if (bit_idx == data_length - 4'd1)
                        state_nxt = parity_control ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) begin
                    par_bad_nxt = (sample != (par_acc ^ parity_select));
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!sample) frm_bad_nxt = 1'b1;
                    // Leave mid-stop-bit so a back-to-back start edge is caught.
                    if (stop_idx == stop_bits) begin
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data     <= '0;
            bus.valid    <= 1'b0;
            bus.ack      <= 1'b1;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;

            if (bus.valid && bus.ready) bus.valid <= 1'b0;

            if (frame_done) begin
                if (bus.valid) begin
                    overrun <= 1'b1;
                end else begin
                    bus.data     <= word;
                    bus.valid    <= 1'b1;
                    parity_error <= par_bad;
                    frame_error  <= frm_bad_nxt;
                end
            end

            if (state == IDLE && !start_go) bus.ack <= bus.req;
            else                            bus.ack <= 1'b0;
        end
    end

endmodule
